// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing a flip-flop register bank between NREQ requesters,
// with optional time-bounded lock for back-to-back streaming and one registered read port.
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int ID_W     = 2,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   lock_expired,
    input  logic [AW-1:0]          rd_addr,
    output logic [DATA_W-1:0]      rd_data
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, WRITE, LOCKED} state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     owner, owner_n, ptr, ptr_n, win, owner_inc;
    logic [CW-1:0]       cnt, cnt_n;
    logic                found, expired_n, wr_en;
    logic                own_valid, own_lock, wr_in_range, rd_in_range;
    logic [AW-1:0]       own_addr;
    logic [DATA_W-1:0]   own_data;
    logic [DATA_W-1:0]   bank [DEPTH];

    assign own_valid = req_valid[owner];
    assign own_lock  = req_lock[owner];
    assign own_addr  = req_addr[int'(owner)*AW +: AW];
    assign own_data  = req_data[int'(owner)*DATA_W +: DATA_W];
    assign owner_inc = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

    // Range checks only exist when the address space is larger than the bank.
    generate
        if (DEPTH < (1 << AW)) begin : g_rng
            assign wr_in_range = own_addr < AW'(DEPTH);
            assign rd_in_range = rd_addr  < AW'(DEPTH);
        end else begin : g_full
            assign wr_in_range = 1'b1;
            assign rd_in_range = 1'b1;
        end
    endgenerate

    // First pending request at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        cnt_n     = cnt;
        expired_n = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = WRITE;
                    owner_n = win;
                end
            end
            WRITE: begin
                wr_en = own_valid;
                if (own_valid && own_lock) begin
                    state_n = LOCKED;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                    ptr_n   = owner_inc;
                end
            end
            LOCKED: begin
                wr_en = own_valid;
                cnt_n = cnt + 1'b1;
                if (!own_lock) begin
                    state_n = IDLE;
                    ptr_n   = owner_inc;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_MAX - 1)) begin
                    state_n   = IDLE;
                    ptr_n     = owner_inc;
                    cnt_n     = '0;
                    expired_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            owner        <= '0;
            ptr          <= '0;
            cnt          <= '0;
            lock_expired <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            lock_expired <= expired_n;
        end
    end

    // Read samples the pre-write contents, so same-address read/write returns the old word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en && wr_in_range) bank[own_addr] <= own_data;
            rd_data <= rd_in_range ? bank[rd_addr] : '0;
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_rdy
            assign req_ready[g] = (state != IDLE) && (owner == ID_W'(g));
        end
    endgenerate

    assign busy     = (state != IDLE);
    assign grant_id = owner;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, single write, round-robin, lock
// streaming, lock timeout and asynchronous reset during a lock.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_lock = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        lock_expired;
    logic [1:0]  rd_addr = '0;
    logic [7:0]  rd_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dff_bank_arbiter #(
        .NREQ(4), .ID_W(2), .DATA_W(8), .DEPTH(4), .AW(2), .LOCK_MAX(8)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id),
        .busy(busy), .lock_expired(lock_expired),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_lock  = '0;
        rstn      = 1'b0;
        repeat (2) tick();
        rstn      = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
        req_addr[i*2 +: 2] = a;
        req_data[i*8 +: 8] = d;
    endtask

    logic [7:0] exp_bank [4];

    initial begin
        // Reset / idle
        repeat (2) tick();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_expired", lock_expired, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            tick();
            chk("idle_read", rd_data, 8'h00);
            chk("idle_busy", busy, 1'b0);
        end

        // Single write, read-before-write on same address
        set_req(0, 2'd2, 8'hA5);
        req_valid = 4'b0001;
        rd_addr   = 2'd2;
        tick();
        chk("single_ready", req_ready, 4'b0001);
        chk("single_busy", busy, 1'b1);
        chk("single_grant", grant_id, 2'd0);
        tick();
        req_valid = '0;
        chk("single_ready_off", req_ready, 4'b0000);
        chk("single_busy_off", busy, 1'b0);
        chk("single_rbw", rd_data, 8'h00);
        tick();
        chk("single_rd", rd_data, 8'hA5);

        // Round-robin fairness
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'h10 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_ready", req_ready, (k % 2 == 0) ? (32'd1 << ((k / 2) % 4)) : 32'd0);
            if (k % 2 == 0) chk("rr_grant", grant_id, (k / 2) % 4);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            tick();
            chk("rr_bank", rd_data, 8'h10 + i);
        end

        // Lock streaming by requester 2 while requester 1 waits
        do_reset();
        set_req(2, 2'd0, 8'h11);
        set_req(1, 2'd1, 8'h77);
        req_lock  = 4'b0100;
        req_valid = 4'b0100;
        tick();
        chk("lk_ready0", req_ready, 4'b0100);
        req_valid = 4'b0110;
        tick();
        chk("lk_ready1", req_ready, 4'b0100);
        set_req(2, 2'd1, 8'h22);
        tick();
        chk("lk_ready2", req_ready, 4'b0100);
        set_req(2, 2'd2, 8'h33);
        tick();
        chk("lk_ready3", req_ready, 4'b0100);
        set_req(2, 2'd3, 8'h44);
        req_lock = 4'b0000;
        tick();
        chk("lk_idle_ready", req_ready, 4'b0000);
        chk("lk_idle_busy", busy, 1'b0);
        req_valid = 4'b0010;
        tick();
        chk("lk_next_ready", req_ready, 4'b0010);
        chk("lk_next_grant", grant_id, 2'd1);
        tick();
        req_valid = '0;
        exp_bank[0] = 8'h11; exp_bank[1] = 8'h77; exp_bank[2] = 8'h33; exp_bank[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            tick();
            chk("lk_bank", rd_data, exp_bank[i]);
        end

        // Lock timeout
        do_reset();
        set_req(0, 2'd0, 8'h05);
        set_req(1, 2'd3, 8'h06);
        req_lock  = 4'b0001;
        req_valid = 4'b0001;
        tick();
        chk("to_write", req_ready, 4'b0001);
        req_valid = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("to_locked_ready", req_ready, 4'b0001);
            chk("to_locked_exp", lock_expired, 1'b0);
        end
        tick();
        chk("to_release_ready", req_ready, 4'b0000);
        chk("to_expired", lock_expired, 1'b1);
        tick();
        chk("to_expired_off", lock_expired, 1'b0);
        chk("to_next_ready", req_ready, 4'b0010);
        chk("to_next_grant", grant_id, 2'd1);
        req_valid = '0;
        req_lock  = '0;
        tick();

        // Asynchronous reset while LOCKED
        do_reset();
        set_req(0, 2'd0, 8'h99);
        set_req(1, 2'd2, 8'h3C);
        req_lock  = 4'b0010;
        req_valid = 4'b0010;
        tick();
        chk("ar_write", req_ready, 4'b0010);
        tick();
        tick();
        chk("ar_locked", req_ready, 4'b0010);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_ready", req_ready, 4'b0000);
        chk("ar_busy", busy, 1'b0);
        req_valid = '0;
        req_lock  = '0;
        rd_addr   = 2'd2;
        tick();
        rstn = 1'b1;
        tick();
        chk("ar_bank", rd_data, 8'h00);
        req_valid = 4'b0011;
        tick();
        chk("ar_first_ready", req_ready, 4'b0001);
        chk("ar_first_grant", grant_id, 2'd0);
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
